// File: rtl/mem_burst_master_pkg.sv
// Shared types and constants for the burst master that drives the 32x32 data memory.
package mem_burst_master_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 32;

    localparam logic MODE_WRITE = 1'b0;
    localparam logic MODE_READ  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        WR_DATA,
        WR_COMMIT,
        RD_ISSUE,
        RD_EXEC,
        RD_CAPT,
        RD_HOLD,
        DONE
    } state_t;

endpackage

// File: rtl/mem_burst_ctr.sv
// Burst address/length tracker: loads a start address and word count, then
// advances one word at a time with a wrapping address.
module mem_burst_ctr
    import mem_burst_master_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              advance,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [ADDR_W:0]   load_len,
    output logic [ADDR_W-1:0] cur_addr,
    output logic [ADDR_W:0]   remain,
    output logic              is_last
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_addr <= '0;
            remain   <= '0;
        end else if (load) begin
            cur_addr <= load_addr;
            remain   <= load_len;
        end else if (advance) begin
            // DEPTH is 2**ADDR_W, so the natural overflow is the wrap to 0
            cur_addr <= cur_addr + 1'b1;
            remain   <= remain - 1'b1;
        end
    end

    assign is_last = (remain == (ADDR_W+1)'(1));

endmodule

// File: rtl/mem_burst_master.sv
// Burst initiator for the single-port data memory: one word per access,
// write data in and read data out over valid/ready handshakes.
//
// state     | meaning
// IDLE      | waiting for a command; rejects illegal lengths with err
// WR_DATA   | waiting for a write word
// WR_COMMIT | memory write strobe high, word captured at end of cycle
// RD_ISSUE  | set up read strobe and address
// RD_EXEC   | memory read strobe high, data_out loads at end of cycle
// RD_CAPT   | register memory data_out into rd_data
// RD_HOLD   | rd_valid high until consumer takes the word
// DONE      | one-cycle done pulse, back to IDLE
module mem_burst_master
    import mem_burst_master_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W:0]   cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              done,
    output logic              err,
    output logic              mem_write_en,
    output logic              mem_mode,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);

    localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(DEPTH);

    state_t            state;
    logic              dir;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W:0]   remain;
    logic              is_last;
    logic              len_ok;
    logic              ctr_load;
    logic              ctr_adv;

    assign cmd_ready = (state == IDLE);
    assign wr_ready  = (state == WR_DATA);
    assign len_ok    = (cmd_len != '0) && (cmd_len <= LEN_MAX);
    assign ctr_load  = (state == IDLE) && cmd_valid;
    // a word is retired after its commit (write) or after the consumer takes it (read)
    assign ctr_adv   = dir ? (state == WR_COMMIT) : ((state == RD_HOLD) && rd_ready);

    mem_burst_ctr #(.ADDR_W(ADDR_W)) u_ctr (
        .clk       (clk),
        .rst       (rst),
        .load      (ctr_load),
        .advance   (ctr_adv),
        .load_addr (cmd_addr),
        .load_len  (cmd_len),
        .cur_addr  (cur_addr),
        .remain    (remain),
        .is_last   (is_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            dir          <= 1'b0;
            mem_write_en <= 1'b0;
            mem_mode     <= MODE_WRITE;
            mem_addr     <= '0;
            mem_data_in  <= '0;
            rd_valid     <= 1'b0;
            rd_data      <= '0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        dir <= cmd_write;
                        if (!len_ok) begin
                            err <= 1'b1;
                        end else begin
                            state <= cmd_write ? WR_DATA : RD_ISSUE;
                        end
                    end
                end
                WR_DATA: begin
                    if (wr_valid) begin
                        mem_write_en <= 1'b1;
                        mem_mode     <= MODE_WRITE;
                        mem_addr     <= cur_addr;
                        mem_data_in  <= wr_data;
                        state        <= WR_COMMIT;
                    end
                end
                WR_COMMIT: begin
                    mem_write_en <= 1'b0;
                    if (is_last) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        state <= WR_DATA;
                    end
                end
                RD_ISSUE: begin
                    mem_write_en <= 1'b1;
                    mem_mode     <= MODE_READ;
                    mem_addr     <= cur_addr;
                    state        <= RD_EXEC;
                end
                RD_EXEC: begin
                    mem_write_en <= 1'b0;
                    state        <= RD_CAPT;
                end
                RD_CAPT: begin
                    rd_data  <= mem_data_out;
                    rd_valid <= 1'b1;
                    state    <= RD_HOLD;
                end
                RD_HOLD: begin
                    if (rd_ready) begin
                        rd_valid <= 1'b0;
                        if (is_last) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            state <= RD_ISSUE;
                        end
                    end
                end
                DONE: begin
                    mem_mode <= MODE_WRITE;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_burst_master.sv
// Bench for mem_burst_master with a behavioural 32x32 memory and a
// word-array reference of the memory contents.
module tb_mem_burst_master;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cmd_valid = 1'b0, cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [AW:0]   cmd_len = '0;
    logic          wr_valid = 1'b0, rd_ready = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          cmd_ready, wr_ready, rd_valid, done, err;
    logic [DW-1:0] rd_data, mem_data_in, mem_dout;
    logic          mem_write_en, mem_mode;
    logic [AW-1:0] mem_addr;

    always #5 clk = ~clk;

    mem_burst_master dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .done(done), .err(err),
        .mem_write_en(mem_write_en), .mem_mode(mem_mode), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .mem_data_out(mem_dout)
    );

    function automatic logic [DW-1:0] pat(input int i);
        return 32'hA500_0000 | DW'(i);
    endfunction

    // Memory model: write echoes the word, read is registered, idle holds.
    logic [DW-1:0] mem [NW];
    bit            mem_init;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < NW; i++) mem[i] <= pat(i);
            mem_dout <= '0;
            mem_init <= 1'b1;
        end else if (mem_write_en) begin
            if (mem_mode == 1'b0) begin
                mem[mem_addr] <= mem_data_in;
                mem_dout      <= mem_data_in;
            end else begin
                mem_dout <= mem[mem_addr];
            end
        end
    end

    int checks = 0, errors = 0;
    int we_cnt = 0, we_consec = 0, done_cnt = 0, done_long = 0, err_cnt = 0;
    bit prev_we = 0, prev_done = 0;
    int addr_q[$];
    logic [DW-1:0] ref_mem [NW];

    always @(negedge clk) begin
        if (mem_write_en === 1'b1) begin
            we_cnt++;
            addr_q.push_back(int'(mem_addr));
            if (prev_we) we_consec++;
        end
        prev_we = (mem_write_en === 1'b1);
        if (done === 1'b1) begin
            done_cnt++;
            if (prev_done) done_long++;
        end
        prev_done = (done === 1'b1);
        if (err === 1'b1) err_cnt++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic issue_cmd(input bit w, input int a, input int l);
        int n = 0;
        @(negedge clk);
        while (cmd_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) check("cmd_ready_timeout", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = AW'(a);
        cmd_len   = (AW+1)'(l);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic send_word(input logic [DW-1:0] d);
        int n = 0;
        while (wr_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) check("wr_ready_timeout", 64'(wr_ready), 64'd1);
        wr_valid = 1'b1;
        wr_data  = d;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    // entered at the negedge where the master sits in the read-issue step
    task automatic recv_word(input logic [DW-1:0] exp, input int stall);
        int n = 0;
        while (rd_valid !== 1'b1 && n < 12) begin @(negedge clk); n++; end
        check("rd_latency", 64'(n), 64'd3);
        for (int s = 0; s < stall; s++) begin
            check("rd_hold_valid", 64'(rd_valid), 64'd1);
            check("rd_hold_data", 64'(rd_data), 64'(exp));
            @(negedge clk);
        end
        check("rd_data", 64'(rd_data), 64'(exp));
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
        check("rd_valid_drop", 64'(rd_valid), 64'd0);
    endtask

    task automatic wait_done();
        int n = 0;
        while (done !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        check("done_seen", 64'(done), 64'd1);
    endtask

    task automatic run_burst(input bit w, input int a, input int l, input logic [DW-1:0] d0,
                             input logic [DW-1:0] d1, input bit exp_err, input int exp_we,
                             input int stall);
        int we0 = we_cnt, dn0 = done_cnt, er0 = err_cnt;
        int bad = -1;
        logic [DW-1:0] d;
        addr_q.delete();
        issue_cmd(w, a, l);
        if (exp_err) begin
            check("err_pulse", 64'(err), 64'd1);
            check("err_cmd_ready", 64'(cmd_ready), 64'd1);
            @(negedge clk);
            check("err_width", 64'(err), 64'd0);
        end else if (w) begin
            for (int i = 0; i < l; i++) begin
                d = (i == 0) ? d0 : (i == 1) ? d1 : d0 + DW'(i);
                ref_mem[(a + i) % NW] = d;
                send_word(d);
            end
            wait_done();
        end else begin
            for (int i = 0; i < l; i++) recv_word(ref_mem[(a + i) % NW], stall);
            wait_done();
        end
        #1;
        check("we_cycles", 64'(we_cnt - we0), 64'(exp_we));
        check("done_count", 64'(done_cnt - dn0), exp_err ? 64'd0 : 64'd1);
        check("err_count", 64'(err_cnt - er0), exp_err ? 64'd1 : 64'd0);
        if (!exp_err) begin
            if (addr_q.size() != l) bad = addr_q.size();
            else for (int i = 0; i < l; i++)
                if (bad < 0 && addr_q[i] != (a + i) % NW) bad = i;
            check("addr_seq_first_bad", 64'(bad), 64'hFFFF_FFFF_FFFF_FFFF);
        end
    endtask

    typedef struct {
        bit          w;
        int          addr;
        int          len;
        logic [31:0] d0;
        logic [31:0] d1;
        bit          exp_err;
        int          exp_we;
        int          stall;
    } vec_t;

    vec_t tbl[11];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] m0, m1;
        int a, l, st;
        bit w, e;

        tbl[0]  = '{1, 0,  2,  231, 423,  0, 2,  0};
        tbl[1]  = '{0, 0,  2,  0,   0,    0, 2,  0};
        tbl[2]  = '{1, 30, 4,  10,  11,   0, 4,  0};
        tbl[3]  = '{0, 0,  2,  0,   0,    0, 2,  0};
        tbl[4]  = '{1, 5,  0,  0,   0,    1, 0,  0};
        tbl[5]  = '{0, 5,  33, 0,   0,    1, 0,  0};
        tbl[6]  = '{1, 31, 1,  77,  0,    0, 1,  0};
        tbl[7]  = '{1, 3,  32, 1000, 1001, 0, 32, 0};
        tbl[8]  = '{0, 3,  32, 0,   0,    0, 32, 1};
        tbl[9]  = '{0, 31, 1,  0,   0,    0, 1,  5};
        tbl[10] = '{0, 0,  63, 0,   0,    1, 0,  0};

        for (int i = 0; i < NW; i++) ref_mem[i] = pat(i);

        // reset
        repeat (2) @(negedge clk);
        check("rst_mem_write_en", 64'(mem_write_en), 64'd0);
        check("rst_mem_mode", 64'(mem_mode), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_data_in", 64'(mem_data_in), 64'd0);
        check("rst_rd_valid", 64'(rd_valid), 64'd0);
        check("rst_rd_data", 64'(rd_data), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_wr_ready", 64'(wr_ready), 64'd0);
        check("rst_we_count", 64'(we_cnt), 64'd0);
        rst = 1'b1;

        for (int i = 0; i < 11; i++)
            run_burst(tbl[i].w, tbl[i].addr, tbl[i].len, tbl[i].d0, tbl[i].d1,
                      tbl[i].exp_err, tbl[i].exp_we, tbl[i].stall);

        // reset in the middle of a 4-word write: only the first two words land
        begin
            int we0;
            m0 = $urandom;
            m1 = $urandom;
            we0 = we_cnt;
            issue_cmd(1, 8, 4);
            send_word(m0);
            send_word(m1);
            @(negedge clk);
            ref_mem[8] = m0;
            ref_mem[9] = m1;
            wr_valid = 1'b1;
            wr_data  = $urandom;
            rst = 1'b0;
            #1;
            check("mid_rst_mem_write_en", 64'(mem_write_en), 64'd0);
            check("mid_rst_mem_addr", 64'(mem_addr), 64'd0);
            check("mid_rst_mem_data_in", 64'(mem_data_in), 64'd0);
            check("mid_rst_cmd_ready", 64'(cmd_ready), 64'd1);
            check("mid_rst_wr_ready", 64'(wr_ready), 64'd0);
            repeat (2) @(negedge clk);
            rst = 1'b1;
            repeat (2) @(negedge clk);
            wr_valid = 1'b0;
            #1;
            check("mid_rst_we_cycles", 64'(we_cnt - we0), 64'd2);
            run_burst(0, 8, 4, 0, 0, 0, 4, 0);
        end

        // randomized bursts against the reference memory
        for (int k = 0; k < 16; k++) begin
            w  = 1'($urandom_range(0, 1));
            a  = int'($urandom_range(0, NW - 1));
            if ($urandom_range(0, 7) == 0) l = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(33, 63));
            else l = int'($urandom_range(1, NW));
            st = int'($urandom_range(0, 2));
            e  = (l == 0) || (l > NW);
            run_burst(w, a, l, $urandom, $urandom, e, e ? 0 : l, st);
        end

        check("we_never_back_to_back", 64'(we_consec), 64'd0);
        check("done_single_cycle", 64'(done_long), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_burst_master.md
Name: mem_burst_master

Overview:
- Initiator for the team's 32x32 single-port data memory.
- Memory port:
  - write_en=1, mode=0: write; the written word is echoed on data_out.
  - write_en=1, mode=1: read, registered on the clock edge.
  - write_en=0: data_out holds its value.
- Accepts burst commands (start address, length, direction) from the core or a DMA source.
- Streams write data in and read data out over valid/ready handshakes.
- Sequences the memory's control pins, one word at a time, with address wrap-around.

Parameters:
- ADDR_W, 5, memory address width.
- DATA_W, 32, data word width.
- DEPTH, 32, number of memory words (2**ADDR_W).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; asynchronous, active-low (0 = reset).
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  high only in IDLE.
- cmd_write  input  1  1 = burst write, 0 = burst read.
- cmd_addr  input  ADDR_W  burst start address.
- cmd_len  input  ADDR_W+1  word count; legal range 1..DEPTH.
- wr_valid  input  1  write word offered.
- wr_ready  output  1  high only in WR_DATA.
- wr_data  input  DATA_W  write word.
- rd_valid  output  1  read word valid.
- rd_ready  input  1  consumer accepts read word.
- rd_data  output  DATA_W  read word.
- done  output  1  one-cycle pulse at the end of a legal burst.
- err  output  1  one-cycle pulse when an illegal length is rejected.
- mem_write_en  output  1  to memory write_en.
- mem_mode  output  1  to memory mode (0 write, 1 read).
- mem_addr  output  ADDR_W  to memory addr.
- mem_data_in  output  DATA_W  to memory data_in.
- mem_data_out  input  DATA_W  from memory data_out.

Behaviour:
- Register file:
  - All outputs are registered except cmd_ready and wr_ready, which decode directly from state.
  - Internal registers: state, cur_addr, remain (ADDR_W+1 bits), dir.
- Reset (rst=0, async): state=IDLE.
  - Registered outputs forced to 0: mem_write_en, mem_mode, mem_addr, mem_data_in, rd_valid, rd_data, done, err.
  - cmd_ready and wr_ready decode from state, so they read 1 and 0 respectively.
  - Reset mid-burst aborts at once; no further mem_write_en pulse; the partial burst is not resumed.
- IDLE:
  - On cmd_valid: latch cur_addr=cmd_addr, remain=cmd_len, dir=cmd_write.
  - cmd_len==0 or cmd_len>DEPTH: err=1 for one cycle, stay IDLE, no memory access.
  - Legal length: go to WR_DATA (write) or RD_ISSUE (read).
- WR_DATA:
  - On wr_valid: mem_write_en<=1, mem_mode<=0, mem_addr<=cur_addr, mem_data_in<=wr_data; go to WR_COMMIT.
- WR_COMMIT:
  - Memory captures the word at the edge ending this cycle.
  - mem_write_en<=0; cur_addr<=cur_addr+1 (mod DEPTH); remain<=remain-1.
  - Go to DONE if remain==1, else WR_DATA.
  - Throughput: 1 word per 2 cycles minimum.
- RD_ISSUE:
  - mem_write_en<=1, mem_mode<=1, mem_addr<=cur_addr; go to RD_EXEC.
- RD_EXEC:
  - Memory loads data_out at the end of this cycle; mem_write_en<=0; go to RD_CAPT.
- RD_CAPT:
  - rd_data<=mem_data_out, rd_valid<=1; go to RD_HOLD.
- RD_HOLD:
  - rd_valid and rd_data stay stable until rd_ready=1.
  - On that edge: rd_valid<=0, advance cur_addr and remain; go to DONE if last, else RD_ISSUE.
  - Read latency: 3 cycles from RD_ISSUE entry to rd_valid.
- DONE:
  - done=1 for exactly one cycle; mem_mode returns to 0; go to IDLE.
- Boundary rules:
  - Address wraps from DEPTH-1 to 0 within a burst.
  - Length DEPTH touches every word exactly once.
  - mem_write_en is never high for two consecutive cycles.
  - mem_data_in changes only on a write issue.
  - cmd_valid outside IDLE is ignored (cmd_ready=0).
  - wr_valid outside WR_DATA is ignored.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, WR_DATA, WR_COMMIT, RD_ISSUE, RD_EXEC, RD_CAPT, RD_HOLD, DONE);
  - the MODE_WRITE=0 / MODE_READ=1 constants;
  - the ADDR_W/DATA_W defaults.
- One natural sub-module, mem_burst_ctr: holds cur_addr/remain with load, advance (wrapping increment and decrement) and an is_last flag.

Test Plan:
- Bench setup: instantiate the team's 32x32 memory wired to the mem_* ports.
- Reset: hold rst=0 for 2 cycles.
  - All registered outputs 0, cmd_ready=1, wr_ready=0.
  - The memory sees no write_en pulse.
- Burst write addr=0, len=2, data 231 then 423, followed by burst read addr=0, len=2.
  - rd_data is 231 then 423.
  - done pulses once per burst.
  - mem_write_en is high for exactly 2 cycles per burst.
- Wrap: write addr=30, len=4, data 10,11,12,13.
  - mem_addr sequence is 30,31,0,1.
  - A read of addr=0, len=2 returns 12,13.
- Illegal length: cmd_len=0, then cmd_len=33.
  - err pulses 1 cycle each.
  - No mem_write_en activity; returns to IDLE with cmd_ready=1.
- Backpressure: read len=1 with rd_ready held 0 for 5 cycles.
  - rd_valid=1 and rd_data stable throughout.
  - On rd_ready=1: rd_valid drops next cycle and done pulses.
- Reset mid-burst: write len=4, assert rst=0 after the 2nd word.
  - Outputs clear immediately; words 3–4 are never written.
  - A subsequent read confirms only words 1–2 were written.
